// File: rtl/iiitb_tlc_pkg.sv
`default_nettype none
// ============================================================================
// Module      : iiitb_tlc_pkg
// Description : Shared constants for the N-way traffic-light controller:
//               lamp encodings, phase encodings, legal approach range and
//               the approach-index width helper.
// Revision    : 1.0 - initial release
// ============================================================================
package iiitb_tlc_pkg;

    // Legal number of approaches (approach 0 is always the main road)
    localparam int unsigned c_N_WAY_MIN = 2;
    localparam int unsigned c_N_WAY_MAX = 8;

    // One-hot lamp encodings, bit order {R,Y,G}
    localparam logic [2:0] c_LAMP_GREEN  = 3'b001;
    localparam logic [2:0] c_LAMP_YELLOW = 3'b010;
    localparam logic [2:0] c_LAMP_RED    = 3'b100;

    // Phase encodings, also the externally visible phase output
    localparam logic [1:0] c_PH_GREEN  = 2'b00;
    localparam logic [1:0] c_PH_YELLOW = 2'b01;
    localparam logic [1:0] c_PH_ALLRED = 2'b10;

    // Width of an approach index: max(1, clog2(n))
    function automatic int unsigned way_width(input int unsigned n);
        return (n > 2) ? $clog2(n) : 1;
    endfunction

endpackage : iiitb_tlc_pkg
`default_nettype wire

// File: rtl/iiitb_tlc_rr_arb.sv
`default_nettype none
// ============================================================================
// Module      : iiitb_tlc_rr_arb
// Description : Round-robin selector over side approaches 1..N_WAY-1.
//               Search starts at last_served+1 and wraps from N_WAY-1 back
//               to 1; approach 0 is never a candidate.
// Revision    : 1.0 - initial release
// ============================================================================
module iiitb_tlc_rr_arb
#(
    parameter int unsigned N_WAY = 4,
    parameter int unsigned WAY_W = 2
)
(
    input  logic [N_WAY-1:0] i_pending,
    input  logic [WAY_W-1:0] i_last_served,
    output logic [WAY_W-1:0] o_grant_idx,
    output logic             o_grant_valid
);

    // One extra bit so last_served + offset cannot overflow before wrapping
    localparam logic [WAY_W:0] c_SIDE_CNT = (WAY_W+1)'(N_WAY - 1);

    logic [WAY_W:0] w_cand;

    // Walk the side approaches in rotated order and grant the first pending one
    always_comb begin
        o_grant_idx   = '0;
        o_grant_valid = 1'b0;
        w_cand        = '0;
        for (int k = 1; k < N_WAY; k++) begin
            w_cand = {1'b0, i_last_served} + (WAY_W+1)'(k);
            if (w_cand > c_SIDE_CNT) begin
                w_cand = w_cand - c_SIDE_CNT;
            end
            if (!o_grant_valid && i_pending[w_cand[WAY_W-1:0]]) begin
                o_grant_valid = 1'b1;
                o_grant_idx   = w_cand[WAY_W-1:0];
            end
        end
    end

endmodule : iiitb_tlc_rr_arb
`default_nettype wire

// File: rtl/iiitb_tlc_nway.sv
`default_nettype none
// ============================================================================
// Module      : iiitb_tlc_nway
// Description : N-way traffic-light controller. Main road (approach 0) rests
//               in green; latched side requests are served round-robin with
//               a yellow and all-red clearance, always returning to the main
//               road between side phases.
// Revision    : 1.0 - initial release
// ============================================================================
module iiitb_tlc_nway
    import iiitb_tlc_pkg::*;
#(
    parameter int unsigned N_WAY       = 4,
    parameter int unsigned T_MIN_GREEN = 10,
    parameter int unsigned T_GREEN     = 6,
    parameter int unsigned T_YELLOW    = 2,
    parameter int unsigned T_ALLRED    = 1
)
(
    input  logic                           clk,
    input  logic                           rst,
    input  logic [N_WAY-1:0]               sensor,
    output logic [3*N_WAY-1:0]             light,
    output logic [way_width(N_WAY)-1:0]    active_way,
    output logic [1:0]                     phase
);

    localparam int unsigned c_WAY_W = way_width(N_WAY);

    // Counter must reach the largest "last cycle" value of any phase
    localparam int unsigned c_T_MAX_A = (T_MIN_GREEN > T_GREEN)  ? T_MIN_GREEN : T_GREEN;
    localparam int unsigned c_T_MAX_B = (T_YELLOW    > T_ALLRED) ? T_YELLOW    : T_ALLRED;
    localparam int unsigned c_T_MAX   = (c_T_MAX_A   > c_T_MAX_B) ? c_T_MAX_A  : c_T_MAX_B;
    localparam int unsigned c_CNT_W   = (c_T_MAX > 1) ? $clog2(c_T_MAX) : 1;

    localparam logic [c_CNT_W-1:0] c_MIN_LAST    = c_CNT_W'(T_MIN_GREEN - 1);
    localparam logic [c_CNT_W-1:0] c_GREEN_LAST  = c_CNT_W'(T_GREEN - 1);
    localparam logic [c_CNT_W-1:0] c_YELLOW_LAST = c_CNT_W'(T_YELLOW - 1);
    localparam logic [c_CNT_W-1:0] c_ALLRED_LAST = c_CNT_W'(T_ALLRED - 1);
    localparam logic [c_CNT_W-1:0] c_CNT_SAT     = '1;

    localparam logic [3*N_WAY-1:0] c_LIGHT_RST = {{(N_WAY-1){c_LAMP_RED}}, c_LAMP_GREEN};

    logic [1:0]          r_phase,   w_phase_nxt;
    logic [c_WAY_W-1:0]  r_way,     w_way_nxt;
    logic [c_CNT_W-1:0]  r_cnt,     w_cnt_nxt;
    logic [N_WAY-1:0]    r_pending, w_pending_nxt;
    logic [c_WAY_W-1:0]  r_last,    w_last_nxt;
    logic [3*N_WAY-1:0]  r_light,   w_light_nxt;

    logic                w_phase_chg;
    logic                w_enter_green;
    logic [c_WAY_W-1:0]  w_arb_idx;
    logic                w_arb_valid;

    iiitb_tlc_rr_arb #(
        .N_WAY (N_WAY),
        .WAY_W (c_WAY_W)
    ) u_rr_arb (
        .i_pending     (r_pending),
        .i_last_served (r_last),
        .o_grant_idx   (w_arb_idx),
        .o_grant_valid (w_arb_valid)
    );

    // State register: phase, owner, counter, request latches and lamps
    always_ff @(posedge clk) begin
        if (rst) begin
            r_phase   <= c_PH_GREEN;
            r_way     <= '0;
            r_cnt     <= '0;
            r_pending <= '0;
            r_last    <= '0;
            r_light   <= c_LIGHT_RST;
        end else begin
            r_phase   <= w_phase_nxt;
            r_way     <= w_way_nxt;
            r_cnt     <= w_cnt_nxt;
            r_pending <= w_pending_nxt;
            r_last    <= w_last_nxt;
            r_light   <= w_light_nxt;
        end
    end

    // Next-state: phase sequencing plus counter, request and last-served updates
    always_comb begin
        w_phase_nxt = r_phase;
        w_way_nxt   = r_way;
        case (r_phase)
            c_PH_GREEN: begin
                if (r_way == '0) begin
                    // Main road rests in green until its minimum expires and someone waits
                    if ((r_cnt >= c_MIN_LAST) && (|r_pending)) begin
                        w_phase_nxt = c_PH_YELLOW;
                    end
                end else if (r_cnt == c_GREEN_LAST) begin
                    w_phase_nxt = c_PH_YELLOW;
                end
            end
            c_PH_YELLOW: begin
                if (r_cnt == c_YELLOW_LAST) begin
                    w_phase_nxt = c_PH_ALLRED;
                end
            end
            c_PH_ALLRED: begin
                if (r_cnt == c_ALLRED_LAST) begin
                    w_phase_nxt = c_PH_GREEN;
                    // After main: next pending side (or main again); after side: main
                    if ((r_way == '0) && w_arb_valid) begin
                        w_way_nxt = w_arb_idx;
                    end else begin
                        w_way_nxt = '0;
                    end
                end
            end
            default: begin
                w_phase_nxt = c_PH_GREEN;
                w_way_nxt   = '0;
            end
        endcase

        w_phase_chg   = (w_phase_nxt != r_phase);
        w_enter_green = w_phase_chg && (w_phase_nxt == c_PH_GREEN);

        // Counter saturates so an idle main green keeps satisfying its minimum
        if (w_phase_chg) begin
            w_cnt_nxt = '0;
        end else if (r_cnt == c_CNT_SAT) begin
            w_cnt_nxt = r_cnt;
        end else begin
            w_cnt_nxt = r_cnt + 1'b1;
        end

        // Bit 0 never latches; the main road needs no request
        w_pending_nxt    = '0;
        w_pending_nxt[0] = sensor[0] & 1'b0;
        for (int i = 1; i < N_WAY; i++) begin
            if (w_enter_green && (w_way_nxt == c_WAY_W'(i))) begin
                w_pending_nxt[i] = 1'b0;
            end else if ((r_phase == c_PH_GREEN) && (r_way == c_WAY_W'(i))) begin
                w_pending_nxt[i] = r_pending[i];
            end else begin
                w_pending_nxt[i] = r_pending[i] | sensor[i];
            end
        end

        if (w_enter_green && (w_way_nxt != '0)) begin
            w_last_nxt = w_way_nxt;
        end else begin
            w_last_nxt = r_last;
        end
    end

    // Output decode: lamps for the upcoming state, registered alongside it
    always_comb begin
        w_light_nxt = '0;
        for (int i = 0; i < N_WAY; i++) begin
            if (w_way_nxt == c_WAY_W'(i)) begin
                case (w_phase_nxt)
                    c_PH_GREEN:  w_light_nxt[3*i +: 3] = c_LAMP_GREEN;
                    c_PH_YELLOW: w_light_nxt[3*i +: 3] = c_LAMP_YELLOW;
                    default:     w_light_nxt[3*i +: 3] = c_LAMP_RED;
                endcase
            end else begin
                w_light_nxt[3*i +: 3] = c_LAMP_RED;
            end
        end
    end

    assign light      = r_light;
    assign active_way = r_way;
    assign phase      = r_phase;

endmodule : iiitb_tlc_nway
`default_nettype wire

// File: tb/tb_iiitb_tlc_nway.sv
`default_nettype none
// ============================================================================
// Module      : tb_iiitb_tlc_nway
// Description : Directed self-checking bench for iiitb_tlc_nway (N_WAY=4,
//               default timings). Expected per-cycle phase/owner sequences
//               are written out by hand as segment tables.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_iiitb_tlc_nway;

    logic        clk;
    logic        rst;
    logic [3:0]  sensor;
    logic [11:0] light;
    logic [1:0]  active_way;
    logic [1:0]  phase;

    int n_vec;
    int n_err;

    int exp_way[$];
    int exp_ph[$];

    iiitb_tlc_nway #(
        .N_WAY       (4),
        .T_MIN_GREEN (10),
        .T_GREEN     (6),
        .T_YELLOW    (2),
        .T_ALLRED    (1)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .sensor     (sensor),
        .light      (light),
        .active_way (active_way),
        .phase      (phase)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one clock and settle just after the edge
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst    = 1'b1;
        sensor = 4'b0000;
        tick();
        tick();
    endtask

    // Append len cycles of (way, phase) to the expected sequence
    task automatic push_seg(input int way, input int ph, input int len);
        for (int k = 0; k < len; k++) begin
            exp_way.push_back(way);
            exp_ph.push_back(ph);
        end
    endtask

    // Independent lamp model: active approach lit by phase, everyone else red
    function automatic logic [11:0] exp_light(input int way, input int ph);
        logic [11:0] l;
        logic [2:0]  lamp;
        l    = 12'b100_100_100_100;
        lamp = (ph == 0) ? 3'b001 : ((ph == 1) ? 3'b010 : 3'b100);
        l[3*way +: 3] = lamp;
        return l;
    endfunction

    task automatic test_reset();
        logic [15:0] got, want;
        rst    = 1'b1;
        sensor = 4'b1110;
        for (int i = 0; i < 5; i++) begin
            tick();
            got  = {active_way, phase, light};
            want = {2'd0, 2'b00, 12'b100_100_100_001};
            n_vec++;
            if (got !== want) begin
                n_err++;
                $display("FAIL reset cycle %0d: got way=%0d phase=%b light=%b, expected way=0 phase=00 light=100100100001",
                         i, active_way, phase, light);
            end
        end
        // Requests seen during reset must not survive it
        rst    = 1'b0;
        sensor = 4'b0000;
        for (int i = 0; i < 14; i++) begin
            tick();
            got  = {active_way, phase, light};
            want = {2'd0, 2'b00, 12'b100_100_100_001};
            n_vec++;
            if (got !== want) begin
                n_err++;
                $display("FAIL reset_no_retain cycle %0d: got way=%0d phase=%b light=%b, expected way=0 phase=00 light=100100100001",
                         i, active_way, phase, light);
            end
        end
    endtask

    task automatic test_single_request();
        logic [15:0] got, want;
        exp_way.delete();
        exp_ph.delete();
        push_seg(0, 0, 9);
        push_seg(0, 1, 2);
        push_seg(0, 2, 1);
        push_seg(2, 0, 6);
        push_seg(2, 1, 2);
        push_seg(2, 2, 1);
        push_seg(0, 0, 4);
        do_reset();
        for (int i = 0; i < exp_way.size(); i++) begin
            rst    = 1'b0;
            sensor = (i == 0) ? 4'b0100 : 4'b0000;
            tick();
            got  = {active_way, phase, light};
            want = {2'(exp_way[i]), 2'(exp_ph[i]), exp_light(exp_way[i], exp_ph[i])};
            n_vec++;
            if (got !== want) begin
                n_err++;
                $display("FAIL single_request cycle %0d: got way=%0d phase=%b light=%b, expected way=%0d phase=%0d light=%b",
                         i, active_way, phase, light, exp_way[i], exp_ph[i], want[11:0]);
            end
        end
    endtask

    task automatic test_round_robin();
        logic [15:0] got, want;
        int ways[4];
        ways = '{1, 2, 3, 1};
        exp_way.delete();
        exp_ph.delete();
        for (int k = 0; k < 4; k++) begin
            push_seg(0, 0, (k == 0) ? 9 : 10);
            push_seg(0, 1, 2);
            push_seg(0, 2, 1);
            push_seg(ways[k], 0, 6);
            push_seg(ways[k], 1, 2);
            push_seg(ways[k], 2, 1);
        end
        push_seg(0, 0, 10);
        push_seg(0, 1, 1);
        do_reset();
        for (int i = 0; i < exp_way.size(); i++) begin
            rst    = 1'b0;
            sensor = 4'b1110;
            tick();
            got  = {active_way, phase, light};
            want = {2'(exp_way[i]), 2'(exp_ph[i]), exp_light(exp_way[i], exp_ph[i])};
            n_vec++;
            if (got !== want) begin
                n_err++;
                $display("FAIL round_robin cycle %0d: got way=%0d phase=%b light=%b, expected way=%0d phase=%0d light=%b",
                         i, active_way, phase, light, exp_way[i], exp_ph[i], want[11:0]);
            end
        end
    endtask

    task automatic test_main_only();
        logic [15:0] got, want;
        do_reset();
        for (int i = 0; i < 40; i++) begin
            rst    = 1'b0;
            sensor = 4'b0001;
            tick();
            got  = {active_way, phase, light};
            want = {2'd0, 2'b00, 12'b100_100_100_001};
            n_vec++;
            if (got !== want) begin
                n_err++;
                $display("FAIL main_only cycle %0d: got way=%0d phase=%b light=%b, expected way=0 phase=00 light=100100100001",
                         i, active_way, phase, light);
            end
        end
    endtask

    task automatic test_reset_mid_yellow();
        logic [15:0] got, want;
        exp_way.delete();
        exp_ph.delete();
        push_seg(0, 0, 9);
        push_seg(0, 1, 2);
        push_seg(0, 2, 1);
        push_seg(3, 0, 6);
        push_seg(3, 1, 1);   // reset lands here, in the first yellow cycle
        push_seg(0, 0, 16);  // cycle 19 onward: aborted to main green, nothing pending
        push_seg(0, 1, 2);
        push_seg(0, 2, 1);
        push_seg(1, 0, 6);
        push_seg(1, 1, 2);
        push_seg(1, 2, 1);
        push_seg(0, 0, 10);
        push_seg(0, 1, 2);
        push_seg(0, 2, 1);
        push_seg(3, 0, 2);
        do_reset();
        for (int i = 0; i < exp_way.size(); i++) begin
            rst = (i == 19) ? 1'b1 : 1'b0;
            if (i == 0)       sensor = 4'b1000;
            else if (i == 14) sensor = 4'b0010;
            else if (i == 34) sensor = 4'b1010;
            else              sensor = 4'b0000;
            tick();
            got  = {active_way, phase, light};
            want = {2'(exp_way[i]), 2'(exp_ph[i]), exp_light(exp_way[i], exp_ph[i])};
            n_vec++;
            if (got !== want) begin
                n_err++;
                $display("FAIL reset_mid_yellow cycle %0d: got way=%0d phase=%b light=%b, expected way=%0d phase=%0d light=%b",
                         i, active_way, phase, light, exp_way[i], exp_ph[i], want[11:0]);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [15:0] got, want;
        exp_way.delete();
        exp_ph.delete();
        push_seg(0, 0, 9);
        push_seg(0, 1, 2);
        push_seg(0, 2, 1);
        push_seg(1, 0, 6);
        push_seg(1, 1, 2);
        push_seg(1, 2, 1);
        push_seg(0, 0, 10);
        push_seg(0, 1, 2);
        push_seg(0, 2, 1);
        push_seg(3, 0, 6);
        push_seg(3, 1, 2);
        push_seg(3, 2, 1);
        push_seg(0, 0, 15);
        do_reset();
        for (int i = 0; i < exp_way.size(); i++) begin
            rst = 1'b0;
            if (i == 0)                  sensor = 4'b0010;
            else if (i == 13 || i == 14) sensor = 4'b1010;
            else                         sensor = 4'b0000;
            tick();
            got  = {active_way, phase, light};
            want = {2'(exp_way[i]), 2'(exp_ph[i]), exp_light(exp_way[i], exp_ph[i])};
            n_vec++;
            if (got !== want) begin
                n_err++;
                $display("FAIL back_to_back cycle %0d: got way=%0d phase=%b light=%b, expected way=%0d phase=%0d light=%b",
                         i, active_way, phase, light, exp_way[i], exp_ph[i], want[11:0]);
            end
        end
    endtask

    initial begin
        n_vec  = 0;
        n_err  = 0;
        rst    = 1'b1;
        sensor = 4'b0000;
        test_reset();
        test_single_request();
        test_round_robin();
        test_main_only();
        test_reset_mid_yellow();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    // Backstop against a stuck simulation
    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, got no finish, expected finish");
        $fatal(1, "watchdog expired");
    end

endmodule : tb_iiitb_tlc_nway
`default_nettype wire
